fib_scheduler: RTL
==================

Name: fib_scheduler

Overview:
- Round-robin scheduler that shares one fibonacci engine between NREQ requesters.
- Grants one requester at a time and loads its n into the engine via the engine's reset/load pulse.
- Masks the engine's stale ready after a load, captures the result when ready arrives, and returns it tagged with the requester id.
- A watchdog returns an error response if the engine never signals ready.

Parameters:
- NREQ, 4, number of requesters.
- ID_BITS, 2, width of resp_id; NREQ <= 2^ID_BITS.
- IN_BITS, 8, width of each n.
- OUT_BITS, 16, width of the result.
- GUARD, 2, cycles after the load during which eng_ready is ignored; must be >= 1.
- TIMEOUT, 1000, maximum WAIT cycles before an error response; must be < 2^TO_BITS.
- TO_BITS, 10, width of the watchdog counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  level request, one bit per requester.
- req_n  input  NREQ*IN_BITS  n for requester i at bits [i*IN_BITS +: IN_BITS].
- grant  output  NREQ  one-hot owner of the engine; zero when idle.
- busy  output  1  high in every state except IDLE.
- resp_valid  output  1  one-cycle response strobe.
- resp_id  output  ID_BITS  index of the requester being answered.
- resp_result  output  OUT_BITS  captured result; 0 on error.
- resp_err  output  1  timeout flag, valid with resp_valid.
- eng_reset  output  1  engine load/hold; the engine samples eng_n while this is high.
- eng_n  output  IN_BITS  n presented to the engine.
- eng_result  input  OUT_BITS  engine result.
- eng_ready  input  1  engine ready.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; grant, resp_valid, resp_err, resp_id, resp_result, eng_n, all counters = 0.
  - eng_reset = 1; rr_ptr = NREQ-1, so requester 0 wins first.
  - Reset mid-operation aborts the job with no response; the requester must retry.
- All outputs are registered.
- States: IDLE, LOAD, GUARD, WAIT, RESP. The engine is parked in IDLE.
- IDLE:
  - eng_reset = 1.
  - If any req bit is set: pick the first set bit searching rr_ptr+1 upward with wrap.
  - On that edge: grant <= onehot(i), rr_ptr <= i, eng_n <= req_n[i], resp_id <= i, go to LOAD.
  - req_n is sampled only at this edge; later changes are ignored.
- LOAD: eng_reset = 1 for exactly one cycle, then GUARD.
- GUARD:
  - eng_reset = 0.
  - eng_ready is ignored for GUARD cycles, counted by a guard counter.
  - Then clear the watchdog and go to WAIT.
- WAIT, on each edge:
  - If eng_ready = 1: resp_result <= eng_result, resp_err <= 0, go to RESP.
  - Else if watchdog == TIMEOUT-1: resp_result <= 0, resp_err <= 1, go to RESP.
  - Else watchdog += 1.
  - If eng_ready and timeout coincide, ready wins.
- RESP:
  - resp_valid = 1 for one cycle; grant is still held.
  - Next state IDLE; on that edge grant <= 0, resp_valid <= 0, eng_reset <= 1.
- Requester contract:
  - Hold req and req_n until the edge that samples resp_valid=1 with a matching resp_id.
  - Deassert req on that edge, so the next IDLE cycle sees it low.
- A requester dropping req while granted does not abort the job; the response is still issued.
- Throughput: one job per (4 + GUARD + wait cycles) minimum.
- Fairness: the most recent winner has the lowest priority; no starvation with NREQ requesters.
- Invariants: grant is one-hot or zero; grant != 0 exactly when state is LOAD, GUARD, WAIT or RESP.

Test Plan:
- Bench engine model: asserts eng_ready with value V exactly L cycles after eng_reset falls.
- Single request: req=0001, n=5, model V=8, L=6 → grant=0001 one cycle after req, one eng_reset load cycle with eng_n=5, resp_valid one cycle with resp_id=0, resp_result=8, resp_err=0, then grant=0.
- Stale ready: model holds eng_ready=1 for the first 2 cycles after the load, then V=21 at L=8 → no capture during GUARD, resp_result=21.
- Round robin: req=1111 held, each requester re-requests after its response → grant order 0,1,2,3,0; resp_id matches each grant.
- Timeout: model never asserts ready, TIMEOUT=1000 → resp_valid exactly 1000 cycles after WAIT entry, resp_err=1, resp_result=0, then next requester granted.
- Async reset mid-WAIT: drop reset between edges → grant=0, busy=0, eng_reset=1 immediately; after release req=0010 is granted fresh; the aborted job produces no resp_valid.
- Coincident ready and timeout in the same cycle → resp_err=0, captured result returned.

Source files
------------

// File: rtl/fib_scheduler_if.sv
// Engine-side bus of the fibonacci scheduler: load/hold control out, result/ready back.
// The scheduler drives the master modport; the fibonacci engine sits on the slave modport.
interface fib_scheduler_if #(
   parameter int unsigned IN_BITS  = 8,
   parameter int unsigned OUT_BITS = 16
);
   logic                eng_reset;
   logic [IN_BITS-1:0]  eng_n;
   logic [OUT_BITS-1:0] eng_result;
   logic                eng_ready;

   modport master (
      output eng_reset,
      output eng_n,
      input  eng_result,
      input  eng_ready
   );

   modport slave (
      input  eng_reset,
      input  eng_n,
      output eng_result,
      output eng_ready
   );
endinterface

// File: rtl/fib_scheduler.sv
// Round-robin scheduler sharing one fibonacci engine between NREQ requesters,
// with a guard window against stale ready and a watchdog that returns an error response.
module fib_scheduler #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned ID_BITS  = 2,
   parameter int unsigned IN_BITS  = 8,
   parameter int unsigned OUT_BITS = 16,
   parameter int unsigned GUARD    = 2,
   parameter int unsigned TIMEOUT  = 1000,
   parameter int unsigned TO_BITS  = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*IN_BITS-1:0]   req_n,
   output logic [NREQ-1:0]           grant,
   output logic                      busy,
   output logic                      resp_valid,
   output logic [ID_BITS-1:0]        resp_id,
   output logic [OUT_BITS-1:0]       resp_result,
   output logic                      resp_err,
   fib_scheduler_if.master           eng
);

   localparam int unsigned G_BITS = $clog2(GUARD + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GUARD,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [ID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IN_BITS-1:0]  eng_n_q, eng_n_d;
   logic                eng_reset_q, eng_reset_d;
   logic [ID_BITS-1:0]  resp_id_q, resp_id_d;
   logic [OUT_BITS-1:0] resp_result_q, resp_result_d;
   logic                resp_err_q, resp_err_d;
   logic                resp_valid_q, resp_valid_d;
   logic                busy_q, busy_d;
   logic [G_BITS-1:0]   guard_q, guard_d;
   logic [TO_BITS-1:0]  wd_q, wd_d;

   logic                win_found;
   logic [ID_BITS-1:0]  win_idx;
   logic [ID_BITS-1:0]  cand;
   logic [IN_BITS-1:0]  win_n;

   // Search starts just past the last winner, so the most recent winner ranks last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      win_n     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = ID_BITS'((32'(rr_ptr_q) + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (ID_BITS'(i) == win_idx) begin
            win_n = req_n[i*IN_BITS +: IN_BITS];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      eng_n_d       = eng_n_q;
      eng_reset_d   = eng_reset_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_err_d    = resp_err_q;
      resp_valid_d  = 1'b0;
      guard_d       = guard_q;
      wd_d          = wd_q;
      unique case (state_q)
         S_IDLE: begin
            eng_reset_d = 1'b1;
            if (win_found) begin
               grant_d   = NREQ'(1) << win_idx;
               rr_ptr_d  = win_idx;
               eng_n_d   = win_n;
               resp_id_d = win_idx;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            eng_reset_d = 1'b0;
            guard_d     = '0;
            state_d     = S_GUARD;
         end
         S_GUARD: begin
            if (guard_q == G_BITS'(GUARD - 1)) begin
               wd_d    = '0;
               state_d = S_WAIT;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         S_WAIT: begin
            // Ready is tested first so a coincident timeout still returns the result.
            if (eng.eng_ready) begin
               resp_result_d = eng.eng_result;
               resp_err_d    = 1'b0;
               resp_valid_d  = 1'b1;
               state_d       = S_RESP;
            end else if (wd_q == TO_BITS'(TIMEOUT - 1)) begin
               resp_result_d = '0;
               resp_err_d    = 1'b1;
               resp_valid_d  = 1'b1;
               state_d       = S_RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_RESP: begin
            grant_d     = '0;
            eng_reset_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= ID_BITS'(NREQ - 1);
         eng_n_q       <= '0;
         eng_reset_q   <= 1'b1;
         resp_id_q     <= '0;
         resp_result_q <= '0;
         resp_err_q    <= 1'b0;
         resp_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         guard_q       <= '0;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         eng_n_q       <= eng_n_d;
         eng_reset_q   <= eng_reset_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_err_q    <= resp_err_d;
         resp_valid_q  <= resp_valid_d;
         busy_q        <= busy_d;
         guard_q       <= guard_d;
         wd_q          <= wd_d;
      end
   end

   assign grant         = grant_q;
   assign busy          = busy_q;
   assign resp_valid    = resp_valid_q;
   assign resp_id       = resp_id_q;
   assign resp_result   = resp_result_q;
   assign resp_err      = resp_err_q;
   assign eng.eng_reset = eng_reset_q;
   assign eng.eng_n     = eng_n_q;

endmodule
